// File: rtl/imm_extend_pipe.sv
//============================================================================
// Module   : imm_extend_pipe
// Purpose  : Immediate-field extender with a valid/ready handshake on both
//            sides. The result is computed at acceptance, then held in an
//            output register backed by a one-entry skid register, so
//            in_ready can be registered and never depends on out_ready.
//            Also counts completed output transfers.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic [1:0]       in_mode,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic [CNT_W-1:0] xfer_cnt
);

    localparam logic [1:0] MODE_SEXT   = 2'b00;
    localparam logic [1:0] MODE_ZEXT   = 2'b01;
    localparam logic [1:0] MODE_UPPER  = 2'b10;
    localparam logic [1:0] MODE_BRANCH = 2'b11;

    logic             skid_valid;
    logic [OUT_W-1:0] skid_data;

    logic             accept;
    logic             complete;
    logic [OUT_W-1:0] sext;
    logic [OUT_W-1:0] result;

    logic             next_out_valid;
    logic [OUT_W-1:0] next_out_data;
    logic             next_skid_valid;
    logic [OUT_W-1:0] next_skid_data;

    assign accept   = in_valid & in_ready;
    assign complete = out_valid & out_ready;
    assign sext     = {{(OUT_W-IN_W){in_data[IN_W-1]}}, in_data};

    // Extend the incoming immediate according to the selected mode
    always_comb begin
        result = sext;
        case (in_mode)
            MODE_SEXT:   result = sext;
            MODE_ZEXT:   result = {{(OUT_W-IN_W){1'b0}}, in_data};
            MODE_UPPER:  result = {in_data, {(OUT_W-IN_W){1'b0}}};
            MODE_BRANCH: result = {sext[OUT_W-3:0], 2'b00};
            default:     result = sext;
        endcase
    end

    // Decide where the accepted word goes and how the output/skid pair evolves.
    // Acceptance with a full skid cannot happen because in_ready tracks it.
    always_comb begin
        next_out_valid  = out_valid;
        next_out_data   = out_data;
        next_skid_valid = skid_valid;
        next_skid_data  = skid_data;
        if (complete) begin
            if (skid_valid) begin
                // Skid entry is older than anything arriving now
                next_out_data   = skid_data;
                next_out_valid  = 1'b1;
                next_skid_valid = 1'b0;
                if (accept) begin
                    next_skid_data  = result;
                    next_skid_valid = 1'b1;
                end
            end else begin
                next_out_valid = accept;
                if (accept) begin
                    next_out_data = result;
                end
            end
        end else if (accept) begin
            if (out_valid) begin
                next_skid_data  = result;
                next_skid_valid = 1'b1;
            end else begin
                next_out_data  = result;
                next_out_valid = 1'b1;
            end
        end
    end

    // State registers; in_ready mirrors the skid occupancy one edge ahead
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_data   <= '0;
            skid_valid <= 1'b0;
            skid_data  <= '0;
            in_ready   <= 1'b0;
        end else begin
            out_valid  <= next_out_valid;
            out_data   <= next_out_data;
            skid_valid <= next_skid_valid;
            skid_data  <= next_skid_data;
            in_ready   <= ~next_skid_valid;
        end
    end

    // Completed-transfer counter, wraps naturally at its width
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt <= '0;
        end else if (complete) begin
            xfer_cnt <= xfer_cnt + CNT_W'(1);
        end
    end

endmodule

`default_nettype wire
